// File: rtl/branch_predictor.sv
// branch_predictor
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// IF looks up the fetch PC combinationally and gets a predicted next PC; EX
// reports each resolved instruction, which trains the table and raises
// mispredict/redirect_pc when the prediction carried down the pipe was wrong.
//
// Parameters: ENTRIES (table depth, power of two 4..256),
//             CTR_INIT (counter value at reset).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   if_pc -> pred_taken, pred_target           combinational lookup
//   ex_valid, ex_stall, ex_pc, ex_pc_step, ex_is_branch, ex_is_jump,
//   ex_taken, ex_target, ex_pred_taken, ex_pred_target   EX resolution
//   mispredict, redirect_pc                    combinational flush/redirect
//   stat_lookups, stat_mispred                 only with BP_STATS_EN
// Optional feature macro: BP_STATS_EN (saturating resolution/mispredict counters).
module branch_predictor #(
    parameter int         ENTRIES  = 32,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_pc_step,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispred
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 31 - IDX_W;

    logic [ENTRIES-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    // Halfword-granular index so compressed instructions get their own slots.
    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;

    assign if_idx = if_pc[IDX_W:1];
    assign if_tag = if_pc[31:IDX_W+1];
    assign ex_idx = ex_pc[IDX_W:1];
    assign ex_tag = ex_pc[31:IDX_W+1];

    // Bit 0 of both PCs never participates in indexing or tagging.
    logic unused_pc_lsb;
    assign unused_pc_lsb = if_pc[0] ^ ex_pc[0];

    // Lookup reads the registered table, so a same-cycle update at the same
    // index is only visible from the next cycle on.
    assign if_hit      = vld_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit & ctr_q[if_idx][1];
    assign pred_target = pred_taken ? tgt_q[if_idx] : 32'h0;

    logic cf, upd, cf_upd, alloc, train, stale;
    logic [1:0] ctr_nxt;

    assign ex_hit = vld_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign cf     = ex_is_branch | ex_is_jump;
    // A stalled EX instruction is seen for several cycles; only the cycle it
    // leaves EX trains the table so each instruction counts exactly once.
    assign upd    = ex_valid & ~ex_stall;
    assign cf_upd = upd & cf;
    assign alloc  = cf_upd & ~ex_hit & ex_taken;
    assign train  = cf_upd & ex_hit;
    // A non-control-flow instruction predicted taken means the entry belongs
    // to code that has since changed (or aliased); drop it.
    assign stale  = upd & ~cf & ex_pred_taken;

    always_comb begin
        ctr_nxt = ctr_q[ex_idx];
        if (ex_is_jump) begin
            ctr_nxt = 2'b11;
        end else if (!ex_hit) begin
            ctr_nxt = 2'b10;                   // fresh branch allocation: weakly taken
        end else if (ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_nxt = ctr_q[ex_idx] + 2'b01;
        end else begin
            if (ctr_q[ex_idx] != 2'b00) ctr_nxt = ctr_q[ex_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
        end else begin
            if (alloc)      vld_q[ex_idx] <= 1'b1;
            else if (stale) vld_q[ex_idx] <= 1'b0;
            if (alloc || train) ctr_q[ex_idx] <= ctr_nxt;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (alloc)              tag_q[ex_idx] <= ex_tag;
        if (cf_upd && ex_taken) tgt_q[ex_idx] <= ex_target;
    end

    assign mispredict = ex_valid &
                        ((cf & (ex_pred_taken != ex_taken)) |
                         (cf & ex_taken & ex_pred_taken & (ex_pred_target != ex_target)) |
                         (~cf & ex_pred_taken));
    assign redirect_pc = (cf & ex_taken) ? ex_target : ex_pc_step;

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else begin
            if (cf_upd && (stat_lookups != 32'hFFFF_FFFF))
                stat_lookups <= stat_lookups + 32'd1;
            if (upd && mispredict && (stat_mispred != 32'hFFFF_FFFF))
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule
